pulse_spacer: RTL

- Source-domain pacer that sits directly upstream of the one-way pulse synchronizer.
- Accepts request pulses at any rate, up to one per cycle, and counts the ones not yet issued.
- Re-emits them as isolated single-cycle pulses spaced at least GAP cycles apart, so the downstream toggle-based synchronizer never merges or loses an event.
- Optional ack mode holds each issue until the far domain confirms receipt.

---
 rtl/rz_sync_pkg.sv | 19 +
 rtl/pulse_spacer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rz_sync_pkg.sv
// ---------------------------------------------------------------------------
// rz_sync_pkg
// Shared definitions for the request-pacing / pulse-synchronizer slice.
//   pulse_spacer_state_t : state encoding of pulse_spacer (IDLE, GAP, WAIT_ACK)
//   PULSE_SPACER_MIN_GAP : smallest legal spacing, checked at elaboration
//   PULSE_SPACER_MAX_GAP : largest legal spacing (gap counter is 8 bits)
// ---------------------------------------------------------------------------
package rz_sync_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GAP      = 2'd1,
      WAIT_ACK = 2'd2
   } pulse_spacer_state_t;

   localparam int PULSE_SPACER_MIN_GAP = 2;
   localparam int PULSE_SPACER_MAX_GAP = 255;

endpackage

// File: rtl/pulse_spacer.sv
// ---------------------------------------------------------------------------
// pulse_spacer
// Source-domain pacer placed in front of a toggle-based pulse synchronizer.
// Every high cycle on 'in' is one request; requests are counted and re-issued
// as isolated single-cycle pulses with rising edges at least GAP cycles apart,
// so the far side never sees two events merge.
//
// Parameters:
//   GAP   : minimum cycles between consecutive out rising edges (2..255)
//   CNT_W : width of the pending-request counter (saturates at all-ones)
//
// Ports:
//   clk          : clock
//   reset_n      : asynchronous active-low reset
//   in           : request pulse, one request per high cycle
//   out          : registered single-cycle pulse to the synchronizer
//   pending      : requests accepted but not yet issued
//   busy         : high while not IDLE or while requests are pending
//   overflow     : sticky flag, a request was dropped at saturation
//   clr_overflow : synchronous clear of overflow (a new drop wins)
//   ack          : far-domain receipt pulse, already synchronized
//                  (only with PULSE_SPACER_ACK_EN)
//
// Build option:
//   PULSE_SPACER_ACK_EN : adds the ack port and the WAIT_ACK state so each
//                         issue also waits for the far side's confirmation.
// ---------------------------------------------------------------------------
module pulse_spacer
   // Only specific items are imported: the state literal GAP would otherwise
   // clash with the GAP parameter, so state literals are always package-scoped.
   import rz_sync_pkg::pulse_spacer_state_t;
   import rz_sync_pkg::PULSE_SPACER_MIN_GAP;
   import rz_sync_pkg::PULSE_SPACER_MAX_GAP;
#(
   parameter int GAP   = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in,
   output logic             out,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             overflow,
   input  logic             clr_overflow
`ifdef PULSE_SPACER_ACK_EN
   ,
   input  logic             ack
`endif
);

   if (GAP < PULSE_SPACER_MIN_GAP || GAP > PULSE_SPACER_MAX_GAP) begin : g_bad_gap
      $error("pulse_spacer: GAP must be within 2..255");
   end

   localparam logic [7:0]       GAP_RELOAD = 8'(GAP - 1);
   localparam logic [CNT_W-1:0] PEND_MAX   = '1;
   localparam logic [CNT_W-1:0] PEND_ONE   = CNT_W'(1);

   pulse_spacer_state_t state_q, state_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]    pending_q, pending_d;
   logic                out_q, out_d;
   logic                overflow_q, overflow_d;
   logic                issue;
   logic                drop;
`ifdef PULSE_SPACER_ACK_EN
   logic                ack_seen_q, ack_seen_d;
`endif

   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      out_d      = 1'b0;

      issue = (state_q == rz_sync_pkg::IDLE) && ((pending_q != '0) || in);
      // A request can only be lost when it cannot be issued straight away
      // and the counter has no room left.
      drop  = in && !issue && (pending_q == PEND_MAX);

      // Arrival and issue in the same cycle cancel out.
      if (in && !issue && !drop) begin
         pending_d = pending_q + PEND_ONE;
      end else if (issue && !in) begin
         pending_d = pending_q - PEND_ONE;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end

      case (state_q)
         rz_sync_pkg::IDLE: begin
            if (issue) begin
               out_d     = 1'b1;
               state_d   = rz_sync_pkg::GAP;
               gap_cnt_d = GAP_RELOAD;
            end
         end
         rz_sync_pkg::GAP: begin
            gap_cnt_d = gap_cnt_q - 8'd1;
            if (gap_cnt_q == 8'd1) begin
`ifdef PULSE_SPACER_ACK_EN
               // An ack that already arrived during the gap lets us skip WAIT_ACK.
               if (ack_seen_q || ack) begin
                  state_d = rz_sync_pkg::IDLE;
               end else begin
                  state_d = rz_sync_pkg::WAIT_ACK;
               end
`else
               state_d = rz_sync_pkg::IDLE;
`endif
            end
         end
`ifdef PULSE_SPACER_ACK_EN
         rz_sync_pkg::WAIT_ACK: begin
            if (ack) begin
               state_d = rz_sync_pkg::IDLE;
            end
         end
`endif
         default: begin
            state_d = rz_sync_pkg::IDLE;
         end
      endcase
   end

`ifdef PULSE_SPACER_ACK_EN
   // ack_seen remembers a confirmation that beats the gap timer; ack while
   // IDLE belongs to no outstanding issue and is ignored.
   always_comb begin
      ack_seen_d = ack_seen_q;
      if (issue) begin
         ack_seen_d = 1'b0;
      end else if (ack && (state_q == rz_sync_pkg::GAP || state_q == rz_sync_pkg::WAIT_ACK)) begin
         ack_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_seen_q <= 1'b0;
      end else begin
         ack_seen_q <= ack_seen_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= rz_sync_pkg::IDLE;
         gap_cnt_q  <= 8'd0;
         pending_q  <= '0;
         out_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         pending_q  <= pending_d;
         out_q      <= out_d;
         overflow_q <= overflow_d;
      end
   end

   assign out      = out_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != rz_sync_pkg::IDLE) || (pending_q != '0);

endmodule
